// File: rtl/fxp_alu_arbiter_if.sv
// fxp_alu_arbiter_if: request/response bundle between requesters and the shared ALU arbiter
interface fxp_alu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [2*NUM_REQ-1:0] req_op;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [23:0] rsp_data;
  logic rsp_overflow;
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input req_ready, rsp_valid, rsp_id, rsp_data, rsp_overflow
  );
  modport slave (
    input req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_overflow
  );
endinterface

// File: rtl/fxp_alu_arbiter.sv
// fxp_alu_arbiter: round-robin sharing of one registered Q8.8 ALU with a tagged response channel
module fxp_alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int OVF_CNT_W = 16
) (
  input logic clk,
  input logic rst,
  fxp_alu_arbiter_if.slave bus,
  output logic [1:0] alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input logic [23:0] alu_out,
  input logic alu_overflow,
  output logic [OVF_CNT_W-1:0] ovf_count,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] rr_ptr, id_r, gnt_id;
  logic gnt_found;
  logic [1:0] op_r;
  logic [15:0] a_r, b_r;
  assign alu_op = op_r;
  assign alu_a = a_r;
  assign alu_b = b_r;
  assign busy = state != IDLE;
  assign bus.req_ready = (state == IDLE && gnt_found) ? NUM_REQ'(1) << gnt_id : '0;
  // round-robin search: walk offsets downward so the smallest offset from rr_ptr wins
  always_comb begin
    gnt_found = 1'b0;
    gnt_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_id = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end
  // sequence each operation through accept, ALU issue, result capture and response handshake
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = gnt_found ? ISSUE : IDLE;
      ISSUE: state_n = CAPTURE;
      CAPTURE: state_n = RESP;
      RESP: state_n = bus.rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // operand latch on accept; operands stay frozen until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_r <= '0;
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
    end else if (state == IDLE && gnt_found) begin
      id_r <= gnt_id;
      op_r <= bus.req_op[2*int'(gnt_id) +: 2];
      a_r <= bus.req_a[16*int'(gnt_id) +: 16];
      b_r <= bus.req_b[16*int'(gnt_id) +: 16];
    end
  end
  // response capture, completion bookkeeping and saturating overflow count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= '0;
      bus.rsp_data <= '0;
      bus.rsp_overflow <= 1'b0;
      ovf_count <= '0;
    end else if (state == CAPTURE) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_id <= id_r;
      bus.rsp_data <= alu_out;
      bus.rsp_overflow <= alu_overflow;
    end else if (state == RESP && bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
      rr_ptr <= (id_r == ID_W'(NUM_REQ - 1)) ? '0 : id_r + 1'b1;
      if (bus.rsp_overflow && ovf_count != '1) ovf_count <= ovf_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fxp_alu_arbiter.sv
// tb_fxp_alu_arbiter: directed checks of arbitration, latency, backpressure, overflow count and reset
module tb_fxp_alu_arbiter;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] alu_op;
  logic [15:0] alu_a, alu_b;
  logic [23:0] alu_out = '0;
  logic alu_overflow = 1'b0;
  logic [CW-1:0] ovf_count;
  logic busy;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_cyc;
  fxp_alu_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();
  fxp_alu_arbiter #(.NUM_REQ(4), .ID_W(2), .OVF_CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .alu_op(alu_op),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_out(alu_out),
    .alu_overflow(alu_overflow),
    .ovf_count(ovf_count),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [24:0] alu_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op == 2'b11 && sb == 0) return {1'b1, 24'h7FFFFF};
    r = op == 2'b00 ? sa + sb : op == 2'b01 ? sa - sb : op == 2'b10 ? (sa * sb) >>> 8 : (sa * 256) / sb;
    if (r > 32767) return {1'b1, 24'h7FFFFF};
    if (r < -32768) return {1'b1, 24'h800000};
    return {1'b0, 24'(r)};
  endfunction
  always @(posedge clk) {alu_overflow, alu_out} <= alu_f(alu_op, alu_a, alu_b);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic set_req(input int id, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.req_op[2*id +: 2] = op;
    bus.req_a[16*id +: 16] = a;
    bus.req_b[16*id +: 16] = b;
    bus.req_valid[id] = 1'b1;
  endtask
  task automatic run_req(input string tag, input int id, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [23:0] exp_d, input logic exp_o, input int exp_cnt);
    @(negedge clk);
    set_req(id, op, a, b);
    #1;
    for (int n = 0; n < 10 && bus.req_ready == 0; n++) step();
    check({tag, "_grant"}, 32'(bus.req_ready), 32'(1) << id);
    step();
    bus.req_valid[id] = 1'b0;
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_early1"}, 32'(bus.rsp_valid), 0);
    step();
    check({tag, "_early2"}, 32'(bus.rsp_valid), 0);
    step();
    check({tag, "_valid"}, 32'(bus.rsp_valid), 1);
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    check({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_d));
    check({tag, "_ovf"}, 32'(bus.rsp_overflow), 32'(exp_o));
    step();
    check({tag, "_done"}, 32'(bus.rsp_valid), 0);
    check({tag, "_cnt"}, 32'(ovf_count), 32'(exp_cnt));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(bus.rsp_valid), 0);
    check("rst_id", 32'(bus.rsp_id), 0);
    check("rst_data", 32'(bus.rsp_data), 0);
    check("rst_cnt", 32'(ovf_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_alu", {14'h0, alu_op, alu_a}, 0);
    rst = 1'b0;
    run_req("add0", 0, 2'b00, 16'h0180, 16'h0240, 24'h0003C0, 1'b0, 0);
    run_req("mul2", 2, 2'b10, 16'h0200, 16'h0300, 24'h000600, 1'b0, 0);
    run_req("addovf1", 1, 2'b00, 16'h7F00, 16'h0200, 24'h7FFFFF, 1'b1, 1);
    run_req("div0_3", 3, 2'b11, 16'h0100, 16'h0000, 24'h7FFFFF, 1'b1, 2);
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, 2'b00, 16'((i + 1) * 256), 16'h0100);
    #1;
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < 10 && bus.req_ready == 0; n++) step();
      check("rr_grant", 32'(bus.req_ready), 32'(1) << (k % 4));
      check("rr_onehot", $countones(bus.req_ready), 1);
      if (k > 0) check("rr_interval", cyc - last_cyc, 4);
      last_cyc = cyc;
      for (int s = 0; s < 3; s++) begin
        step();
        check("rr_noready", 32'(bus.req_ready), 0);
      end
      if (k == 4) bus.req_valid = '0;
      check("rr_rsp_id", 32'(bus.rsp_id), 32'(k % 4));
      check("rr_rsp_data", 32'(bus.rsp_data), 32'(((k % 4) + 2) * 256));
    end
    step();
    bus.rsp_ready = 1'b0;
    set_req(2, 2'b01, 16'h0500, 16'h0200);
    set_req(0, 2'b00, 16'h0100, 16'h0100);
    #1;
    check("bp_grant", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid[2] = 1'b0;
    step();
    step();
    for (int s = 0; s < 5; s++) begin
      check("bp_valid", 32'(bus.rsp_valid), 1);
      check("bp_id", 32'(bus.rsp_id), 2);
      check("bp_data", 32'(bus.rsp_data), 32'h300);
      check("bp_ovf", 32'(bus.rsp_overflow), 0);
      check("bp_noready", 32'(bus.req_ready), 0);
      if (s < 4) step();
    end
    bus.rsp_ready = 1'b1;
    step();
    check("bp_done", 32'(bus.rsp_valid), 0);
    check("bp_next_grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid[0] = 1'b0;
    #1;
    check("drop_ready", 32'(bus.req_ready), 0);
    step();
    check("drop_idle", 32'(busy), 0);
    run_req("sat_a", 0, 2'b11, 16'h0100, 16'h0000, 24'h7FFFFF, 1'b1, 3);
    run_req("sat_b", 0, 2'b11, 16'h0100, 16'h0000, 24'h7FFFFF, 1'b1, 3);
    @(negedge clk);
    set_req(3, 2'b00, 16'h0100, 16'h0100);
    #1;
    check("mid_grant", 32'(bus.req_ready), 32'h8);
    step();
    bus.req_valid[3] = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("mid_valid", 32'(bus.rsp_valid), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_data", 32'(bus.rsp_data), 0);
    check("mid_cnt", 32'(ovf_count), 0);
    check("mid_alu", {14'h0, alu_op, alu_a}, 0);
    rst = 1'b0;
    step();
    set_req(1, 2'b00, 16'h0100, 16'h0100);
    set_req(3, 2'b00, 16'h0100, 16'h0100);
    #1;
    check("post_grant", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = '0;
    step();
    step();
    check("post_valid", 32'(bus.rsp_valid), 1);
    check("post_id", 32'(bus.rsp_id), 1);
    check("post_data", 32'(bus.rsp_data), 32'h200);
    step();
    check("post_done", 32'(bus.rsp_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
